// File: rtl/mc_traffic_checker.sv
// rtl/mc_traffic_checker.sv - write/read traffic generator and in-order read checker
module mc_traffic_checker #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 30,
    parameter int NUM_OPS      = 1023,
    parameter int CNT_WIDTH    = 32,
    parameter int IDLE_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  ctrl_busy,
    output logic                  req_valid,
    output logic                  req_type,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    input  logic                  rd_done,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [CNT_WIDTH-1:0]  first_err_idx,
    output logic [CNT_WIDTH-1:0]  write_cycles,
    output logic [CNT_WIDTH-1:0]  total_cycles
);
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_OP   = CNT_WIDTH'(NUM_OPS - 1);
    localparam logic [CNT_WIDTH-1:0] OP_COUNT  = CNT_WIDTH'(NUM_OPS);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [CNT_WIDTH-1:0]  issue_idx;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [CNT_WIDTH-1:0]  exp_idx;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [IDLE_W-1:0]     idle_cnt;

    logic                  xfer;
    logic                  checking;
    logic                  indexed;
    logic                  wd_fire;
    logic [15:0]           err_nxt;
    logic [CNT_WIDTH-1:0]  first_nxt;
    logic [CNT_WIDTH-1:0]  exp_idx_nxt;
    logic [DATA_WIDTH-1:0] exp_data_nxt;
    logic [IDLE_W-1:0]     idle_nxt;

    // Read-return scoreboard and watchdog; returns outside the checking window are errors.
    always_comb begin
        xfer         = req_valid && !ctrl_busy;
        checking     = (state == S_READ) || (state == S_DRAIN);
        indexed      = checking && (exp_idx < OP_COUNT);
        err_nxt      = err_count;
        first_nxt    = first_err_idx;
        exp_idx_nxt  = exp_idx;
        exp_data_nxt = exp_data;
        idle_nxt     = '0;
        wd_fire      = 1'b0;
        if (rd_done) begin
            if (indexed) begin
                exp_idx_nxt  = exp_idx + 1'b1;
                exp_data_nxt = exp_data + 1'b1;
                if (rd_data != (exp_data ^ seed_q)) begin
                    if (err_count != '1) begin
                        err_nxt = err_count + 16'd1;
                    end
                    if (first_err_idx == '1) begin
                        first_nxt = exp_idx;
                    end
                end
            end else if (err_count != '1) begin
                err_nxt = err_count + 16'd1;
            end
        end
        if (checking && !rd_done) begin
            if (idle_cnt == IDLE_LAST) begin
                wd_fire = 1'b1;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req_valid     <= 1'b0;
            req_type      <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            write_cycles  <= '0;
            total_cycles  <= '0;
            base_q        <= '0;
            stride_q      <= '0;
            seed_q        <= '0;
            issue_idx     <= '0;
            issue_data    <= '0;
            exp_idx       <= '0;
            exp_data      <= '0;
            idle_cnt      <= '0;
        end else begin
            err_count     <= err_nxt;
            first_err_idx <= first_nxt;
            exp_idx       <= exp_idx_nxt;
            exp_data      <= exp_data_nxt;
            idle_cnt      <= idle_nxt;
            if (busy && total_cycles != '1) begin
                total_cycles <= total_cycles + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_WRITE;
                        base_q        <= base_addr;
                        stride_q      <= stride;
                        seed_q        <= seed;
                        req_valid     <= 1'b1;
                        req_type      <= 1'b1;
                        req_addr      <= base_addr;
                        req_data      <= seed;
                        issue_idx     <= '0;
                        issue_data    <= '0;
                        exp_idx       <= '0;
                        exp_data      <= '0;
                        idle_cnt      <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        write_cycles  <= '0;
                        total_cycles  <= '0;
                    end
                end
                S_WRITE: begin
                    if (write_cycles != '1) begin
                        write_cycles <= write_cycles + 1'b1;
                    end
                    if (xfer) begin
                        if (issue_idx == LAST_OP) begin
                            // Read op 0 goes out on the very next cycle.
                            state     <= S_READ;
                            req_type  <= 1'b0;
                            req_addr  <= base_q;
                            req_data  <= '0;
                            issue_idx <= '0;
                        end else begin
                            issue_idx  <= issue_idx + 1'b1;
                            issue_data <= issue_data + 1'b1;
                            req_addr   <= req_addr + stride_q;
                            req_data   <= (issue_data + 1'b1) ^ seed_q;
                        end
                    end
                end
                S_READ: begin
                    if (wd_fire) begin
                        state     <= S_DONE;
                        req_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                    end else if (xfer) begin
                        if (issue_idx == LAST_OP) begin
                            state     <= S_DRAIN;
                            req_valid <= 1'b0;
                        end else begin
                            issue_idx <= issue_idx + 1'b1;
                            req_addr  <= req_addr + stride_q;
                        end
                    end
                end
                S_DRAIN: begin
                    if (exp_idx == OP_COUNT) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 16'd0);
                    end else if (wd_fire) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_traffic_checker.sv
// tb/tb_mc_traffic_checker.sv - directed self-checking bench for mc_traffic_checker
module tb_mc_traffic_checker;
    localparam int DW = 16;
    localparam int AW = 30;
    localparam int N  = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [DW-1:0] seed = '0;
    logic          ctrl_busy = 1'b0;
    logic          mem_done = 1'b0;
    logic          spur_done = 1'b0;
    logic          rd_done;
    logic [DW-1:0] rd_data = '0;
    logic          req_valid, req_type, busy, done, pass, timeout;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [15:0]   err_count;
    logic [CW-1:0] first_err_idx, write_cycles, total_cycles;

    assign rd_done = mem_done | spur_done;

    mc_traffic_checker #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_OPS(N), .CNT_WIDTH(CW), .IDLE_TIMEOUT(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
        .seed(seed), .ctrl_busy(ctrl_busy), .req_valid(req_valid), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .rd_done(rd_done), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_idx(first_err_idx), .write_cycles(write_cycles), .total_cycles(total_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: stores writes, returns reads 2 cycles after acceptance.
    int            cyc = 0;
    int            busy_mode = 0;
    int            corrupt_idx = -1;
    int            drop_idx = -1;
    int            wr_n = 0;
    int            rd_n = 0;
    logic [AW-1:0] w_addr [8];
    logic [DW-1:0] w_data [8];
    logic [AW-1:0] r_addr [8];
    int            w_cyc [8];
    int            r_cyc [8];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            due_q [$];
    logic [DW-1:0] dat_q [$];
    logic          stalled = 1'b0;
    logic [AW+DW:0] held = '0;
    logic [DW-1:0] rdv;

    always @(negedge clk) begin
        cyc++;
        ctrl_busy = (busy_mode != 0) && cyc[0];
        if (stalled) begin
            check_eq("hold_valid", {63'd0, req_valid}, 64'd1);
            check_eq("hold_payload", {17'd0, req_type, req_addr, req_data}, {17'd0, held});
        end
        stalled = req_valid && ctrl_busy;
        held = {req_type, req_addr, req_data};
        mem_done = 1'b0;
        rd_data = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_done = 1'b1;
            rd_data = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end
        if (req_valid && !ctrl_busy) begin
            if (req_type) begin
                if (wr_n < 8) begin
                    w_addr[wr_n] = req_addr;
                    w_data[wr_n] = req_data;
                    w_cyc[wr_n] = cyc;
                end
                mem[req_addr] = req_data;
                wr_n++;
            end else begin
                rdv = mem.exists(req_addr) ? mem[req_addr] : '0;
                if (rd_n == corrupt_idx) rdv = rdv ^ 16'h0001;
                if (rd_n != drop_idx) begin
                    due_q.push_back(cyc + 2);
                    dat_q.push_back(rdv);
                end
                if (rd_n < 8) begin
                    r_addr[rd_n] = req_addr;
                    r_cyc[rd_n] = cyc;
                end
                rd_n++;
            end
        end
    end

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [DW-1:0] sd,
                       input int bm, input int ci, input int di);
        @(posedge clk); #2;
        busy_mode = bm;
        corrupt_idx = ci;
        drop_idx = di;
        wr_n = 0;
        rd_n = 0;
        base_addr = b;
        stride = s;
        seed = sd;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(posedge clk); #2;
            k++;
        end
        check_eq("done_seen", {63'd0, done}, 64'd1);
    endtask

    logic [AW-1:0] wrap_exp [4];

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_err", {48'd0, err_count}, 64'd0);
        check_eq("rst_first", {32'd0, first_err_idx}, 64'hFFFF_FFFF);
        check_eq("rst_total", {32'd0, total_cycles}, 64'd0);
        rst_n = 1'b1;

        // Ideal memory, linear addresses, seed 0.
        run(30'd0, 30'd1, 16'h0000, 0, -1, -1);
        wait_done(100);
        check_eq("t1_writes", wr_n, N);
        check_eq("t1_reads", rd_n, N);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("t1_waddr%0d", k), {34'd0, w_addr[k]}, k);
            check_eq($sformatf("t1_wdata%0d", k), {48'd0, w_data[k]}, k);
            check_eq($sformatf("t1_raddr%0d", k), {34'd0, r_addr[k]}, k);
        end
        check_eq("t1_w_b2b", w_cyc[3] - w_cyc[0], 3);
        check_eq("t1_no_bubble", r_cyc[0], w_cyc[3] + 1);
        check_eq("t1_pass", {63'd0, pass}, 64'd1);
        check_eq("t1_err", {48'd0, err_count}, 64'd0);
        check_eq("t1_timeout", {63'd0, timeout}, 64'd0);
        check_eq("t1_busy", {63'd0, busy}, 64'd0);
        check_eq("t1_first", {32'd0, first_err_idx}, 64'hFFFF_FFFF);
        check_eq("t1_wcyc", {32'd0, write_cycles}, 64'd4);
        check_eq("t1_tcyc", {32'd0, total_cycles}, 64'd11);

        // Controller busy every other cycle, non-unit stride, non-zero seed.
        run(30'h100, 30'd3, 16'hA5A5, 1, -1, -1);
        wait_done(200);
        check_eq("t2_writes", wr_n, N);
        check_eq("t2_reads", rd_n, N);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("t2_waddr%0d", k), {34'd0, w_addr[k]}, 64'h100 + 3 * k);
            check_eq($sformatf("t2_wdata%0d", k), {48'd0, w_data[k]}, 64'hA5A5 ^ k);
            check_eq($sformatf("t2_raddr%0d", k), {34'd0, r_addr[k]}, 64'h100 + 3 * k);
        end
        check_eq("t2_pass", {63'd0, pass}, 64'd1);
        check_eq("t2_err", {48'd0, err_count}, 64'd0);

        // Corrupted return of op 2.
        run(30'd0, 30'd1, 16'h0000, 0, 2, -1);
        wait_done(100);
        check_eq("t3_err", {48'd0, err_count}, 64'd1);
        check_eq("t3_first", {32'd0, first_err_idx}, 64'd2);
        check_eq("t3_pass", {63'd0, pass}, 64'd0);

        // Address wrap at the top of the address space.
        wrap_exp[0] = 30'h3FFF_FFFE;
        wrap_exp[1] = 30'h3FFF_FFFF;
        wrap_exp[2] = 30'h0;
        wrap_exp[3] = 30'h1;
        run(30'h3FFF_FFFE, 30'd1, 16'h1234, 0, -1, -1);
        wait_done(100);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("t4_waddr%0d", k), {34'd0, w_addr[k]}, {34'd0, wrap_exp[k]});
        end
        check_eq("t4_pass", {63'd0, pass}, 64'd1);

        // Last read never returns: watchdog, then a spurious return in DONE.
        run(30'h40, 30'd2, 16'h0F0F, 0, -1, 3);
        wait_done(400);
        check_eq("t5_timeout", {63'd0, timeout}, 64'd1);
        check_eq("t5_pass", {63'd0, pass}, 64'd0);
        check_eq("t5_err", {48'd0, err_count}, 64'd0);
        check_eq("t5_tcyc", {32'd0, total_cycles}, 64'd209);
        check_eq("t5_reads", rd_n, N);
        @(posedge clk); #2;
        spur_done = 1'b1;
        @(posedge clk); #2;
        spur_done = 1'b0;
        check_eq("t5_spur_err", {48'd0, err_count}, 64'd1);
        check_eq("t5_spur_done", {63'd0, done}, 64'd1);
        check_eq("t5_spur_first", {32'd0, first_err_idx}, 64'hFFFF_FFFF);

        // Reset in the middle of the read phase.
        run(30'd0, 30'd1, 16'h0000, 0, -1, -1);
        for (int k = 0; k < 50 && rd_n < 2; k++) begin
            @(posedge clk); #2;
        end
        check_eq("t6_in_read", {63'd0, req_type}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #2;
        due_q.delete();
        dat_q.delete();
        check_eq("t6_req_valid", {63'd0, req_valid}, 64'd0);
        check_eq("t6_busy", {63'd0, busy}, 64'd0);
        check_eq("t6_done", {63'd0, done}, 64'd0);
        check_eq("t6_err", {48'd0, err_count}, 64'd0);
        check_eq("t6_first", {32'd0, first_err_idx}, 64'hFFFF_FFFF);
        check_eq("t6_wcyc", {32'd0, write_cycles}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check_eq("t6_idle_valid", {63'd0, req_valid}, 64'd0);
        check_eq("t6_idle_err", {48'd0, err_count}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
